seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter: SETTLE_CYC, default 8, consecutive unchanged clk edges required before a digit is sampled (legal 2..255).
REQ-002 Parameter: TIMEOUT_CYC, default 4096, clk edges without a completed value before stale asserts (legal 16..2^20).
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: digit_seg  input  8  multiplexed segment bus, bit7=a .. bit1=g, bit0=dp, 1=lit.
REQ-006 Port: digit_cath  input  2  digit select; 2'b01 = low digit, 2'b10 = high digit, 2'b00/2'b11 = none.
REQ-007 Port: value  output  8  last fully decoded byte {high nibble, low nibble}.
REQ-008 Port: value_valid  output  1  one-cycle pulse when value updates.
REQ-009 Port: value_changed  output  1  one-cycle pulse, coincident with value_valid, when new value differs from previous value.
REQ-010 Port: seg_err  output  1  one-cycle pulse on sampling an undecodable segment pattern.
REQ-011 Port: stale  output  1  level; no value completed for TIMEOUT_CYC edges.

Function
REQ-012 Inputs registered once (seg_q, cath_q); all decisions use registered copies.
REQ-013 stable_cnt: cleared on any edge where {digit_seg,digit_cath} differs from {seg_q,cath_q}; else increments, saturating at SETTLE_CYC.
REQ-014 Sample event: the edge on which stable_cnt goes from SETTLE_CYC-1 to SETTLE_CYC; exactly one sample per dwell; held inputs never resample.
REQ-015 cath_q of 2'b00 or 2'b11 at sample event: no action, no error.
REQ-016 Decode table (hex seg -> nibble): FC0 601 DA2 F23 664 B65 BE6 E07 FE8 F69 EEA 3EB 9CC 7AD 9EE 8EF; dp bit must be 0.
REQ-017 Pattern outside table (incl. dp=1): seg_err=1 for that cycle, corresponding have_lo/have_hi cleared, nibble register unchanged.
REQ-018 Valid pattern at cath 01: lo_nib <= nibble, have_lo <= 1; at cath 10: hi_nib, have_hi likewise.
REQ-019 Completion: sample event that sets one have bit while the other is already 1 -> same edge: value <= {hi,lo} using the just-decoded nibble, value_valid=1, have_lo/have_hi both cleared.
REQ-020 Repeat of same digit before its partner: overwrites that nibble, no completion.
REQ-021 value_changed=1 only on completion edges where new value != prior value register; first completion after reset compares against 8'h00.
REQ-022 Timeout counter: cleared on every completion edge, else increments saturating at TIMEOUT_CYC; stale = (counter == TIMEOUT_CYC); stale drops on the completion edge itself.
REQ-023 value holds between completions; pulses are never wider than one cycle.
REQ-024 Latency: value/value_valid visible after edge SETTLE_CYC+1 following the last input change of the completing digit (1 register + SETTLE_CYC).

Reset
REQ-025 rst=1 asynchronously forces: value=8'h00, value_valid=0, value_changed=0, seg_err=0, stale=0, stable_cnt=0, timeout=0, have_lo=have_hi=0, lo_nib=hi_nib=0, seg_q=0, cath_q=0.
REQ-026 Reset mid-dwell or mid-pair discards partial digits; after release a full new low+high pair is required before value_valid.

Verification
REQ-027 Reset release, cath=01 seg=F6 for 20 cycles, then cath=10 seg=60 for 20 cycles -> one value_valid with value=8'h19, value_changed=1, seg_err never.
REQ-028 Repeat same alternation 3 times -> value_valid three pulses total (one per pair), value_changed only on the first.
REQ-029 cath=01 seg=FC held 5 cycles (< SETTLE_CYC) alternating with cath=10 seg=FC -> no sample, no value_valid; after 4096+ cycles stale=1.
REQ-030 cath=01 seg=FF held 20 cycles -> seg_err single pulse, have_lo=0; following cath=10 seg=EE does not complete.
REQ-031 cath=11 and cath=00 dwells of 50 cycles each between valid digits -> ignored; pair 3E/9C still yields 8'hCB.
REQ-032 Assert rst for 1 cycle after the low digit of a pair -> high digit alone produces no value_valid; value reads 8'h00.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Recovers a byte from a scanned two-digit 7-segment display; each digit is sampled once after settling.
// Result is visible SETTLE_CYC+1 edges after the completing digit's last input change; there is no backpressure.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] digit_seg,
  input  logic [1:0] digit_cath,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       value_changed,
  output logic       seg_err,
  output logic       stale
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    SETTLE_V   = 8'(SETTLE_CYC);
  localparam logic [7:0]    SETTLE_M1  = 8'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_V  = TW'(TIMEOUT_CYC);

  logic [7:0]    seg_q, seg_d;
  logic [1:0]    cath_q, cath_d;
  logic [7:0]    stable_q, stable_d;
  logic [TW-1:0] to_q, to_d;
  logic          have_lo_q, have_lo_d, have_hi_q, have_hi_d;
  logic [3:0]    lo_q, lo_d, hi_q, hi_d;
  logic [7:0]    value_q, value_d;
  logic          vld_q, vld_d, chg_q, chg_d, err_q, err_d;

  logic          in_changed, sample, complete;
  logic [4:0]    dec;
  logic [7:0]    new_value;

  // Returns {valid, nibble}; any lit decimal point makes the pattern invalid.
  function automatic logic [4:0] decode(input logic [7:0] s);
    case (s)
      8'hFC: decode = 5'h10;
      8'h60: decode = 5'h11;
      8'hDA: decode = 5'h12;
      8'hF2: decode = 5'h13;
      8'h66: decode = 5'h14;
      8'hB6: decode = 5'h15;
      8'hBE: decode = 5'h16;
      8'hE0: decode = 5'h17;
      8'hFE: decode = 5'h18;
      8'hF6: decode = 5'h19;
      8'hEE: decode = 5'h1A;
      8'h3E: decode = 5'h1B;
      8'h9C: decode = 5'h1C;
      8'h7A: decode = 5'h1D;
      8'h9E: decode = 5'h1E;
      8'h8E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    seg_d     = digit_seg;
    cath_d    = digit_cath;
    stable_d  = stable_q;
    have_lo_d = have_lo_q;
    have_hi_d = have_hi_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    value_d   = value_q;
    vld_d     = 1'b0;
    chg_d     = 1'b0;
    err_d     = 1'b0;
    complete  = 1'b0;
    new_value = value_q;
    to_d      = to_q;

    in_changed = {digit_seg, digit_cath} != {seg_q, cath_q};
    if (in_changed) begin
      stable_d = 8'd0;
    end else if (stable_q != SETTLE_V) begin
      stable_d = stable_q + 8'd1;
    end
    // Saturation at SETTLE_CYC guarantees exactly one sample per dwell.
    sample = !in_changed && (stable_q == SETTLE_M1);
    dec    = decode(seg_q);

    if (sample && (cath_q == 2'b01 || cath_q == 2'b10)) begin
      if (!dec[4]) begin
        err_d = 1'b1;
        if (cath_q == 2'b01) have_lo_d = 1'b0;
        else                 have_hi_d = 1'b0;
      end else if (cath_q == 2'b01) begin
        lo_d = dec[3:0];
        if (have_hi_q) begin
          complete  = 1'b1;
          new_value = {hi_q, dec[3:0]};
        end else begin
          have_lo_d = 1'b1;
        end
      end else begin
        hi_d = dec[3:0];
        if (have_lo_q) begin
          complete  = 1'b1;
          new_value = {dec[3:0], lo_q};
        end else begin
          have_hi_d = 1'b1;
        end
      end
    end

    if (complete) begin
      value_d   = new_value;
      vld_d     = 1'b1;
      chg_d     = (new_value != value_q);
      have_lo_d = 1'b0;
      have_hi_d = 1'b0;
      to_d      = '0;
    end else if (to_q != TIMEOUT_V) begin
      to_d = to_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q     <= 8'h00;
      cath_q    <= 2'b00;
      stable_q  <= 8'd0;
      to_q      <= '0;
      have_lo_q <= 1'b0;
      have_hi_q <= 1'b0;
      lo_q      <= 4'h0;
      hi_q      <= 4'h0;
      value_q   <= 8'h00;
      vld_q     <= 1'b0;
      chg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      cath_q    <= cath_d;
      stable_q  <= stable_d;
      to_q      <= to_d;
      have_lo_q <= have_lo_d;
      have_hi_q <= have_hi_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      value_q   <= value_d;
      vld_q     <= vld_d;
      chg_q     <= chg_d;
      err_q     <= err_d;
    end
  end

  assign value         = value_q;
  assign value_valid   = vld_q;
  assign value_changed = chg_q;
  assign seg_err       = err_q;
  assign stale         = (to_q == TIMEOUT_V);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus random dwells against a dwell-level model.
module tb_seg_scan_decoder;

  localparam int S = 8;
  localparam int T = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] digit_seg = 8'h00;
  logic [1:0] digit_cath = 2'b00;
  logic [7:0] value;
  logic       value_valid, value_changed, seg_err, stale;

  seg_scan_decoder #(.SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .digit_seg(digit_seg), .digit_cath(digit_cath),
    .value(value), .value_valid(value_valid), .value_changed(value_changed),
    .seg_err(seg_err), .stale(stale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vld_seen = 0;

  logic [7:0] pat [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // Model state: which digits are pending, their nibbles, last value, edges since last completion.
  logic       m_have_lo, m_have_hi;
  logic [3:0] m_lo, m_hi;
  logic [7:0] m_value;
  int         m_since;
  logic [9:0] prev_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [7:0] s);
    for (int i = 0; i < 16; i++) if (pat[i] == s) return i;
    return -1;
  endfunction

  task automatic do_reset();
    digit_seg  = 8'h00;
    digit_cath = 2'b00;
    rst = 1'b1;
    #1;
    check("rst_value", value, 0);
    check("rst_vld", value_valid, 0);
    check("rst_chg", value_changed, 0);
    check("rst_err", seg_err, 0);
    check("rst_stale", stale, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_have_lo = 0; m_have_hi = 0; m_lo = 0; m_hi = 0; m_value = 0; m_since = 0;
    prev_in = 10'h000;
  endtask

  // Holds one input pattern for len edges; a dwell samples on its (S+1)-th edge.
  task automatic dwell(input logic [7:0] seg, input logic [1:0] cath, input int len);
    logic e_err, done;
    logic [7:0] newv;
    int idx;
    digit_seg  = seg;
    digit_cath = cath;
    prev_in    = {seg, cath};
    for (int k = 0; k < len; k++) begin
      @(posedge clk);
      #1;
      e_err = 0; done = 0; newv = m_value;
      if (k == S && (cath == 2'b01 || cath == 2'b10)) begin
        idx = lookup(seg);
        if (idx < 0) begin
          e_err = 1;
          if (cath == 2'b01) m_have_lo = 0; else m_have_hi = 0;
        end else if (cath == 2'b01) begin
          m_lo = idx[3:0];
          if (m_have_hi) done = 1; else m_have_lo = 1;
        end else begin
          m_hi = idx[3:0];
          if (m_have_lo) done = 1; else m_have_hi = 1;
        end
      end
      if (done) begin
        newv = {m_hi, m_lo};
        check("value_changed", value_changed, newv != m_value);
        m_value = newv;
        m_have_lo = 0; m_have_hi = 0;
        m_since = 0;
      end else begin
        check("value_changed", value_changed, 0);
        if (m_since < T) m_since++;
      end
      check("value_valid", value_valid, done);
      check("seg_err", seg_err, e_err);
      check("value", value, m_value);
      check("stale", stale, m_since == T);
      if (value_valid) vld_seen++;
    end
  endtask

  initial begin
    logic [7:0] s;
    logic [1:0] c;
    int r, len;
    #2;
    do_reset();

    // Single pair, then two repeats of the same pair.
    vld_seen = 0;
    dwell(8'hF6, 2'b01, 20);
    dwell(8'h60, 2'b10, 20);
    check("pair_value", value, 8'h19);
    for (int i = 0; i < 2; i++) begin
      dwell(8'hF6, 2'b01, 20);
      dwell(8'h60, 2'b10, 20);
    end
    check("pair_pulses", vld_seen, 3);

    // Idle cathode codes between digits are ignored.
    dwell(8'h3E, 2'b01, 20);
    dwell(8'hFF, 2'b11, 50);
    dwell(8'h55, 2'b00, 50);
    dwell(8'h9C, 2'b10, 20);
    check("idle_value", value, 8'hCB);

    // Bad pattern clears the pending low digit.
    vld_seen = 0;
    dwell(8'hFF, 2'b01, 20);
    dwell(8'hEE, 2'b10, 20);
    check("bad_no_pulse", vld_seen, 0);

    // Reset between digits discards the low digit.
    dwell(8'hF6, 2'b01, 20);
    do_reset();
    dwell(8'h60, 2'b10, 20);
    check("rst_pair_value", value, 8'h00);

    // Short dwells never sample; timeout eventually flags stale.
    do_reset();
    vld_seen = 0;
    for (int i = 0; i < 420; i++) begin
      dwell(8'hFC, 2'b01, 5);
      dwell(8'hFC, 2'b10, 5);
    end
    check("short_no_pulse", vld_seen, 0);
    check("stale_set", stale, 1);
    dwell(8'hF6, 2'b01, 20);
    dwell(8'h60, 2'b10, 20);
    check("stale_clear", stale, 0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      r = $urandom_range(0, 9);
      c = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      s = ($urandom_range(0, 9) < 7) ? pat[$urandom_range(0, 15)] : 8'($urandom);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, S) : $urandom_range(S + 1, 2 * S + 6);
      if ({s, c} == prev_in) s = s ^ 8'h01;
      dwell(s, c, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
